rx_sequencer: RTL and testbench

Receive-path controller for the bdv2 modem. It arms the demodulator via `rx_enable`, waits for a completed 16-bit word (`dm_status` pulse) with a programmable timeout, and buffers words in a small FIFO. It also raises `int_rx_host` and exposes control, status and data registers on the 8-bit host bus. It sits between the demodulator/decoder datapath and the register field, and replaces ad-hoc gating of the demodulator clock with a single clocked sequencer.

---
 rtl/bdv2_pkg.sv | 15 +
 rtl/rx_word_fifo.sv | 46 ++++
 rtl/rx_sequencer.sv | 129 ++++++++++++
 tb/tb_rx_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bdv2_pkg.sv
// Shared types and register map for the bdv2 receive path.
package bdv2_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_STORE} rx_state_t;

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h01;
  localparam logic [7:0] ADDR_DATA_LO = 8'h02;
  localparam logic [7:0] ADDR_DATA_HI = 8'h03;
  localparam logic [7:0] ADDR_TIMEOUT = 8'h04;

  localparam int CTRL_START   = 0;
  localparam int CTRL_CONT    = 1;
  localparam int CTRL_IRQ_CLR = 2;
  localparam int CTRL_ABORT   = 3;
endpackage

// File: rtl/rx_word_fifo.sv
// DEPTH x 16 synchronous FIFO; when full, a same-cycle pop frees the slot for the push.
module rx_word_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [15:0]              din,
  output logic [15:0]              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/rx_sequencer.sv
// Receive sequencer: arms the demodulator, waits for a word with timeout,
// buffers words and exposes CTRL/STATUS/DATA/TIMEOUT on the host bus.
module rx_sequencer
  import bdv2_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int TO_SHIFT = 4
) (
  input  logic        G_CLK_RX,
  input  logic        reset,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  DATA_IN,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [7:0]  DATA_OUT,
  output logic        rx_enable,
  output logic        dm_clear,
  input  logic        dm_status,
  input  logic [15:0] dm_data,
  output logic        int_rx_host
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = 8 + TO_SHIFT;

  rx_state_t     state, next;
  logic [7:0]    timeout_q;
  logic [TW-1:0] to_cnt;
  logic [15:0]   word_q, head;
  logic [CW-1:0] fill;
  logic          cont_q, to_flag, ovf_flag;
  logic          full, empty, push, pop, to_hit;
  logic          wr_ctrl, start, abort, irq_clr, start_ok, ovf_set;
  logic [7:0]    rd_mux;

  assign wr_ctrl  = write_enable && (ADDRESS == ADDR_CTRL);
  assign start    = wr_ctrl && DATA_IN[CTRL_START];
  assign abort    = wr_ctrl && DATA_IN[CTRL_ABORT];
  assign irq_clr  = wr_ctrl && DATA_IN[CTRL_IRQ_CLR];
  assign start_ok = start && !abort && (state == S_IDLE);
  assign pop      = read_enable && (ADDRESS == ADDR_DATA_HI) && !empty;
  assign ovf_set  = push && full && !pop;

  always_comb begin
    next      = state;
    rx_enable = 1'b0;
    dm_clear  = 1'b0;
    push      = 1'b0;
    to_hit    = 1'b0;
    case (state)
      S_IDLE:  if (start) next = S_ARM;
      S_ARM: begin
        rx_enable = 1'b1;
        dm_clear  = 1'b1;
        next      = S_WAIT;
      end
      S_WAIT: begin
        rx_enable = 1'b1;
        if (dm_status) next = S_STORE;
        else if (to_cnt == '0 && timeout_q != 8'h00) begin
          to_hit = 1'b1;
          next   = S_IDLE;
        end
      end
      S_STORE: begin
        push = 1'b1;
        next = cont_q ? S_ARM : S_IDLE;
      end
      default: next = S_IDLE;
    endcase
    // Abort overrides everything, including a word landing this cycle.
    if (abort) begin
      next   = S_IDLE;
      push   = 1'b0;
      to_hit = 1'b0;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (ADDRESS)
      ADDR_STATUS:  rd_mux = {2'b00, 3'(fill), ovf_flag, to_flag, state != S_IDLE};
      ADDR_DATA_LO: rd_mux = empty ? 8'h00 : head[7:0];
      ADDR_DATA_HI: rd_mux = empty ? 8'h00 : head[15:8];
      ADDR_TIMEOUT: rd_mux = timeout_q;
      default:      rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge G_CLK_RX) begin
    if (reset) begin
      state       <= S_IDLE;
      timeout_q   <= 8'h00;
      to_cnt      <= '0;
      word_q      <= 16'h0000;
      cont_q      <= 1'b0;
      to_flag     <= 1'b0;
      ovf_flag    <= 1'b0;
      int_rx_host <= 1'b0;
      DATA_OUT    <= 8'h00;
    end else begin
      state <= next;
      if (wr_ctrl) cont_q <= DATA_IN[CTRL_CONT];
      if (write_enable && ADDRESS == ADDR_TIMEOUT) timeout_q <= DATA_IN;
      if (state == S_ARM) to_cnt <= TW'(timeout_q) << TO_SHIFT;
      else if (state == S_WAIT && to_cnt != '0) to_cnt <= to_cnt - 1'b1;
      if (state == S_WAIT && dm_status) word_q <= dm_data;
      // Set events win over a same-cycle clear.
      if (to_hit) to_flag <= 1'b1;
      else if (irq_clr || start_ok) to_flag <= 1'b0;
      if (ovf_set) ovf_flag <= 1'b1;
      else if (irq_clr || start_ok) ovf_flag <= 1'b0;
      if (to_hit || push) int_rx_host <= 1'b1;
      else if (irq_clr) int_rx_host <= 1'b0;
      if (read_enable) DATA_OUT <= rd_mux;
    end
  end

  rx_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (G_CLK_RX),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (word_q),
    .head  (head),
    .count (fill),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_rx_sequencer.sv
// Scoreboard bench for rx_sequencer: reads push expected bytes, a monitor pops and compares.
module tb_rx_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ADDRESS = 8'h00;
  logic [7:0]  DATA_IN = 8'h00;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [7:0]  DATA_OUT;
  logic        rx_enable, dm_clear, int_rx_host;
  logic        dm_status = 1'b0;
  logic [15:0] dm_data = 16'h0000;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];
  string      nm_q[$];
  logic       rd_d = 1'b0;

  rx_sequencer #(.DEPTH(4), .TO_SHIFT(4)) dut (
    .G_CLK_RX     (clk),
    .reset        (reset),
    .ADDRESS      (ADDRESS),
    .DATA_IN      (DATA_IN),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .DATA_OUT     (DATA_OUT),
    .rx_enable    (rx_enable),
    .dm_clear     (dm_clear),
    .dm_status    (dm_status),
    .dm_data      (dm_data),
    .int_rx_host  (int_rx_host)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endfunction

  always @(posedge clk) rd_d <= read_enable;

  always @(negedge clk) begin
    if (rd_d) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL rd_unexpected: got 0x%0h want no read", DATA_OUT);
      end else begin
        chk(nm_q.pop_front(), int'(DATA_OUT), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    ADDRESS = a; DATA_IN = d; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
    ADDRESS = a; read_enable = 1'b1;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    tick();
    read_enable = 1'b0;
  endtask

  task automatic feed(input logic [15:0] w);
    tick();
    dm_status = 1'b1; dm_data = w;
    tick();
    dm_status = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    chk("rst_rx_enable", rx_enable, 0);
    chk("rst_int", int_rx_host, 0);
    chk("rst_dm_clear", dm_clear, 0);
    chk("rst_data_out", DATA_OUT, 0);
    rd(8'h01, 8'h00, "rst_status");
    rd(8'h04, 8'h00, "rst_timeout");

    // single word, no timeout
    wr(8'h04, 8'h00);
    wr(8'h00, 8'h01);
    chk("arm_rx_enable", rx_enable, 1);
    chk("arm_dm_clear", dm_clear, 1);
    tick();
    chk("wait_dm_clear", dm_clear, 0);
    chk("wait_rx_enable", rx_enable, 1);
    repeat (3) tick();
    dm_status = 1'b1; dm_data = 16'hA55A;
    tick();
    dm_status = 1'b0;
    chk("store_rx_enable", rx_enable, 0);
    tick();
    chk("word_int", int_rx_host, 1);
    rd(8'h01, 8'h08, "status_one_word");
    rd(8'h02, 8'h5A, "word_lo");
    rd(8'h03, 8'hA5, "word_hi");
    rd(8'h01, 8'h00, "status_after_pop");
    wr(8'h00, 8'h04);
    chk("irq_clr_int", int_rx_host, 0);

    // timeout
    wr(8'h04, 8'h02);
    rd(8'h04, 8'h02, "timeout_rb");
    rd(8'h07, 8'h00, "bad_addr");
    wr(8'h00, 8'h01);
    n = 0;
    while (rx_enable === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("to_rx_en_cycles", n, 34);
    chk("to_int", int_rx_host, 1);
    rd(8'h01, 8'h02, "to_status");
    wr(8'h00, 8'h04);
    chk("to_irq_clr", int_rx_host, 0);
    rd(8'h01, 8'h00, "to_status_clr");
    wr(8'h04, 8'h00);

    // continuous mode with overflow
    wr(8'h00, 8'h03);
    for (int w = 1; w <= 5; w++) feed(16'(w));
    chk("cont_rx_enable", rx_enable, 1);
    wr(8'h00, 8'h08);
    chk("cont_abort_rx_en", rx_enable, 0);
    rd(8'h01, 8'h24, "ovf_status");
    for (int w = 1; w <= 4; w++) begin
      rd(8'h02, 8'(w), "ovf_lo");
      rd(8'h03, 8'h00, "ovf_hi");
    end
    rd(8'h03, 8'h00, "empty_hi");
    rd(8'h01, 8'h04, "ovf_drained");
    wr(8'h00, 8'h04);
    rd(8'h01, 8'h00, "ovf_cleared");

    // abort coincident with dm_status
    wr(8'h00, 8'h01);
    tick();
    dm_status = 1'b1; dm_data = 16'hBEEF;
    ADDRESS = 8'h00; DATA_IN = 8'h08; write_enable = 1'b1;
    tick();
    dm_status = 1'b0; write_enable = 1'b0;
    chk("abort_rx_enable", rx_enable, 0);
    tick();
    chk("abort_int", int_rx_host, 0);
    rd(8'h01, 8'h00, "abort_status");

    // pop during STORE with full FIFO
    wr(8'h00, 8'h03);
    for (int w = 0; w < 4; w++) feed(16'h0010 + 16'(w));
    tick();
    dm_status = 1'b1; dm_data = 16'h0120;
    tick();
    dm_status = 1'b0;
    rd(8'h03, 8'h00, "hi_in_store");
    wr(8'h00, 8'h08);
    rd(8'h01, 8'h20, "pop_push_status");
    rd(8'h02, 8'h11, "pp_lo0");
    rd(8'h03, 8'h00, "pp_hi0");
    rd(8'h02, 8'h12, "pp_lo1");
    rd(8'h03, 8'h00, "pp_hi1");
    rd(8'h02, 8'h13, "pp_lo2");
    rd(8'h03, 8'h00, "pp_hi2");
    rd(8'h02, 8'h20, "pp_lo3");
    rd(8'h03, 8'h01, "pp_hi3");
    rd(8'h01, 8'h00, "pp_empty_status");

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
